matmul_tile_agu_v2: RTL and testbench
=====================================

MATMUL_TILE_AGU_V2 -- requirements
Module: matmul_tile_agu_v2

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, address width in bits.
REQ-002 SHALL have parameter DIM_W, default 8, width of the tile-count config fields.
REQ-003 SHALL have parameter TILE_SIZE, default 16, address step between horizontally adjacent tiles.
REQ-004 SHALL have port clk  input  1  single clock; one clock domain; reset is synchronous and active-high.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  job launch pulse; sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  cancel the running job.
REQ-008 SHALL have ports cfg_m, cfg_n, cfg_k  input  DIM_W each  tile counts M, N, K.
REQ-009 SHALL have ports base_a, base_b, base_c  input  ADDR_W each  matrix base addresses.
REQ-010 SHALL have ports stride_a, stride_b, stride_c  input  ADDR_W each  address step per tile row.
REQ-011 SHALL have port phase_en  input  3  enables: bit0 A, bit1 B, bit2 C.
REQ-012 SHALL have port addr_ready  input  1  consumer accepts the address.
REQ-013 SHALL have port addr_valid  output  1  addr/addr_id are valid.
REQ-014 SHALL have port addr  output  ADDR_W  tile address.
REQ-015 SHALL have port addr_id  output  matrix_id_t  MAT_A/MAT_B/MAT_C; MAT_INVALID when addr_valid is low.
REQ-016 SHALL have port addr_last  output  1  marks the final address of the job.
REQ-017 SHALL have ports busy and done  output  1 each  busy = job active; done = 1-cycle completion pulse.

Function
REQ-018 SHALL implement FSM states AGU_IDLE, AGU_INIT, AGU_GEN (tile_agu_state_t) and track the current phase with tile_phase_t.
REQ-019 IDLE->INIT when start=1; INIT latches all cfg/base/stride/phase_en inputs and clears counters; INIT->GEN next cycle; GEN->IDLE after the final handshake or abort.
REQ-020 Inputs other than addr_ready/abort SHALL be ignored outside IDLE/INIT; start while busy SHALL be ignored.
REQ-021 Loop order: mi over 0..M-1 (outer), ni over 0..N-1, ki over 0..K-1 (inner); per ki emit A then B; after ki=K-1 emit C.
REQ-022 A = base_a + mi*stride_a + ki*TILE_SIZE; B = base_b + ki*stride_b + ni*TILE_SIZE; C = base_c + mi*stride_c + ni*TILE_SIZE; all mod 2^ADDR_W.
REQ-023 Addresses SHALL be produced with accumulating row/column registers (no multipliers).
REQ-024 Phases with phase_en bit = 0 SHALL be skipped with no bubble cycle; when C is disabled the k loop still runs.
REQ-025 Handshake: transfer when addr_valid && addr_ready; while addr_valid && !addr_ready, addr/addr_id/addr_last SHALL hold stable; addr_valid SHALL not drop without a transfer except on abort/rst.
REQ-026 With addr_ready held high, one address SHALL transfer per cycle; the first addr_valid appears 2 cycles after start is sampled.
REQ-027 addr_last SHALL be high only on the last enabled-phase address at mi=M-1, ni=N-1 (and ki=K-1 for A/B).
REQ-028 done SHALL pulse 1 cycle in the cycle after the addr_last transfer, coincident with return to IDLE; busy high in INIT and GEN.
REQ-029 If any of M, N, K is 0 or phase_en=0, GEN SHALL emit no address and done SHALL pulse the cycle after INIT.
REQ-030 abort in INIT/GEN: next cycle IDLE, addr_valid=0, no done pulse; abort in IDLE has no effect; abort wins over a same-cycle transfer.

Reset
REQ-031 rst=1 at any clock edge SHALL force IDLE, addr_valid=0, addr=0, addr_id=MAT_INVALID, addr_last=0, busy=0, done=0, and clear all counters, including mid-job.
REQ-032 rst SHALL take priority over start and abort.

Verification
REQ-033 M=N=K=1, phase_en=111, bases 0x100/0x200/0x300, ready=1 -> 0x100(A), 0x200(B), 0x300(C, last); done next cycle.
REQ-034 M=1,N=2,K=2, stride_b=0x40, TILE_SIZE=16 -> 0x100 A, 0x200 B, 0x110 A, 0x240 B, 0x300 C, 0x100 A, 0x210 B, 0x110 A, 0x250 B, 0x310 C(last).
REQ-035 addr_ready low 3 cycles on 2nd address of REQ-033 -> 0x200/MAT_B held 4 cycles, no duplicates or drops.
REQ-036 phase_en=100, M=N=2, K=3, stride_c=0x80 -> C only: 0x300, 0x310, 0x380, 0x390(last).
REQ-037 cfg_k=0, start -> no addr_valid, done 2 cycles after start is sampled; abort or rst during REQ-034 -> IDLE next cycle, outputs at reset values, no done.

Source files
------------

// File: rtl/matmul_tile_agu_v2.sv
// matmul_tile_agu_v2 -- tile address generator for a blocked matrix multiply.
//
// For a job of M x N output tiles with K reduction steps it emits, in order:
//   for mi, for ni: { for ki: A(mi,ki), B(ki,ni) } then C(mi,ni)
// Disabled phases (phase_en) are skipped without bubbles. Addresses are built
// from accumulating row/column offsets, so there are no multipliers.
//
// Ports
//   clk, rst              : clock, synchronous active-high reset
//   start, abort          : job launch (IDLE only) / cancel running job
//   cfg_m/n/k             : tile counts, latched in INIT
//   base_*/stride_*       : per-matrix base and row stride, latched in INIT
//   phase_en              : bit0 A, bit1 B, bit2 C
//   addr_valid/ready      : valid/ready handshake for addr, addr_id, addr_last
//   busy, done            : job active / one-cycle completion pulse

package matmul_tile_agu_v2_pkg;
  typedef enum logic [1:0] {MAT_INVALID = 2'd0, MAT_A = 2'd1, MAT_B = 2'd2, MAT_C = 2'd3} matrix_id_t;
  typedef enum logic [1:0] {AGU_IDLE = 2'd0, AGU_INIT = 2'd1, AGU_GEN = 2'd2} tile_agu_state_t;
  typedef enum logic [1:0] {PH_A = 2'd0, PH_B = 2'd1, PH_C = 2'd2} tile_phase_t;
endpackage

module matmul_tile_agu_v2
  import matmul_tile_agu_v2_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DIM_W     = 8,
  parameter int TILE_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_n,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [ADDR_W-1:0] stride_a,
  input  logic [ADDR_W-1:0] stride_b,
  input  logic [ADDR_W-1:0] stride_c,
  input  logic [2:0]        phase_en,
  input  logic              addr_ready,
  output logic              addr_valid,
  output logic [ADDR_W-1:0] addr,
  output matrix_id_t        addr_id,
  output logic              addr_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] TILE = ADDR_W'(TILE_SIZE);
  localparam logic [DIM_W-1:0]  ONE  = DIM_W'(1);

  tile_agu_state_t state, state_nxt;
  tile_phase_t     ph;
  logic            done_r, done_nxt;

  // latched job config
  logic [DIM_W-1:0]  m_r, n_r, k_r;
  logic [ADDR_W-1:0] base_a_r, base_b_r, base_c_r;
  logic [ADDR_W-1:0] stride_a_r, stride_b_r, stride_c_r;
  logic [2:0]        en_r;

  // loop counters and accumulated offsets
  logic [DIM_W-1:0]  mi, ni, ki;
  logic [ADDR_W-1:0] row_a;   // mi*stride_a
  logic [ADDR_W-1:0] row_c;   // mi*stride_c
  logic [ADDR_W-1:0] koff;    // ki*TILE
  logic [ADDR_W-1:0] kb;      // ki*stride_b
  logic [ADDR_W-1:0] ncol;    // ni*TILE

  logic xfer, is_last, k_end, n_end, m_end, empty_in;

  // First phase of an (mi,ni) block; C alone skips the k loop entirely.
  function automatic tile_phase_t first_phase(input logic [2:0] en);
    if (en[0])      return PH_A;
    else if (en[1]) return PH_B;
    else            return PH_C;
  endfunction

  assign empty_in = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0) || (phase_en == 3'b000);
  assign xfer     = (state == AGU_GEN) && addr_ready;
  assign k_end    = (ki == k_r - ONE);
  assign n_end    = (ni == n_r - ONE);
  assign m_end    = (mi == m_r - ONE);
  // Final address: last (mi,ni) block, and either its C or, with C off,
  // the last enabled of A/B at ki=K-1.
  assign is_last  = m_end && n_end &&
                    ((ph == PH_C) || (k_end && !en_r[2] && ((ph == PH_B) || !en_r[1])));

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      AGU_IDLE: if (start) state_nxt = AGU_INIT;
      AGU_INIT: begin
        if (abort) state_nxt = AGU_IDLE;
        else if (empty_in) begin
          // nothing to emit: finish straight away
          state_nxt = AGU_IDLE;
          done_nxt  = 1'b1;
        end else state_nxt = AGU_GEN;
      end
      AGU_GEN: begin
        if (abort) state_nxt = AGU_IDLE;
        else if (xfer && is_last) begin
          state_nxt = AGU_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = AGU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= AGU_IDLE;
      done_r     <= 1'b0;
      ph         <= PH_A;
      m_r        <= '0;
      n_r        <= '0;
      k_r        <= '0;
      base_a_r   <= '0;
      base_b_r   <= '0;
      base_c_r   <= '0;
      stride_a_r <= '0;
      stride_b_r <= '0;
      stride_c_r <= '0;
      en_r       <= '0;
      mi         <= '0;
      ni         <= '0;
      ki         <= '0;
      row_a      <= '0;
      row_c      <= '0;
      koff       <= '0;
      kb         <= '0;
      ncol       <= '0;
    end else begin
      state  <= state_nxt;
      done_r <= done_nxt;
      if (state == AGU_INIT) begin
        m_r        <= cfg_m;
        n_r        <= cfg_n;
        k_r        <= cfg_k;
        base_a_r   <= base_a;
        base_b_r   <= base_b;
        base_c_r   <= base_c;
        stride_a_r <= stride_a;
        stride_b_r <= stride_b;
        stride_c_r <= stride_c;
        en_r       <= phase_en;
        ph         <= first_phase(phase_en);
        mi         <= '0;
        ni         <= '0;
        ki         <= '0;
        row_a      <= '0;
        row_c      <= '0;
        koff       <= '0;
        kb         <= '0;
        ncol       <= '0;
      end else if (xfer && !abort) begin
        if (ph == PH_A && en_r[1]) begin
          ph <= PH_B;
        end else if (ph != PH_C && !k_end) begin
          // next reduction step; A/B phase implies en_r[1:0] != 0
          ki   <= ki + ONE;
          koff <= koff + TILE;
          kb   <= kb + stride_b_r;
          ph   <= en_r[0] ? PH_A : PH_B;
        end else if (ph != PH_C && en_r[2]) begin
          ph <= PH_C;
        end else begin
          // block (mi,ni) finished: rewind k, step n then m
          ki   <= '0;
          koff <= '0;
          kb   <= '0;
          ph   <= first_phase(en_r);
          if (!n_end) begin
            ni   <= ni + ONE;
            ncol <= ncol + TILE;
          end else begin
            ni    <= '0;
            ncol  <= '0;
            mi    <= mi + ONE;
            row_a <= row_a + stride_a_r;
            row_c <= row_c + stride_c_r;
          end
        end
      end
    end
  end

  // Outputs are decoded from held registers, so they stay stable under stall.
  always_comb begin
    addr_valid = 1'b0;
    addr       = '0;
    addr_id    = MAT_INVALID;
    addr_last  = 1'b0;
    if (state == AGU_GEN) begin
      addr_valid = 1'b1;
      addr_last  = is_last;
      case (ph)
        PH_A: begin addr = base_a_r + row_a + koff; addr_id = MAT_A; end
        PH_B: begin addr = base_b_r + kb + ncol;    addr_id = MAT_B; end
        default: begin addr = base_c_r + row_c + ncol; addr_id = MAT_C; end
      endcase
    end
  end

  assign busy = (state != AGU_IDLE);
  assign done = done_r;

endmodule

// File: tb/tb_matmul_tile_agu_v2.sv
// Randomized self-checking bench for matmul_tile_agu_v2 with a loop-nest
// reference model producing the expected address stream.
module tb_matmul_tile_agu_v2;
  import matmul_tile_agu_v2_pkg::*;

  logic clk = 1'b0;
  logic rst, start, abort, addr_ready;
  logic [7:0]  cfg_m, cfg_n, cfg_k;
  logic [15:0] base_a, base_b, base_c, stride_a, stride_b, stride_c;
  logic [2:0]  phase_en;
  logic        addr_valid, addr_last, busy, done;
  logic [15:0] addr;
  matrix_id_t  addr_id;

  matmul_tile_agu_v2 #(.ADDR_W(16), .DIM_W(8), .TILE_SIZE(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .base_a(base_a), .base_b(base_b), .base_c(base_c),
    .stride_a(stride_a), .stride_b(stride_b), .stride_c(stride_c),
    .phase_en(phase_en), .addr_ready(addr_ready), .addr_valid(addr_valid),
    .addr(addr), .addr_id(addr_id), .addr_last(addr_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    matrix_id_t  id;
    logic        last;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_cyc = -10;
  bit   rmode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the plain loop nest with multiplications.
  function automatic void build(input int m, input int n, input int k, input logic [2:0] en,
                                input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                                input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] sc);
    exp_t e;
    exp_q.delete();
    for (int mi = 0; mi < m; mi++)
      for (int ni = 0; ni < n; ni++) begin
        for (int ki = 0; ki < k; ki++) begin
          if (en[0]) begin e.a = 16'(ba + mi*sa + ki*16); e.id = MAT_A; e.last = 1'b0; exp_q.push_back(e); end
          if (en[1]) begin e.a = 16'(bb + ki*sb + ni*16); e.id = MAT_B; e.last = 1'b0; exp_q.push_back(e); end
        end
        if (en[2] && k > 0) begin e.a = 16'(bc + mi*sc + ni*16); e.id = MAT_C; e.last = 1'b0; exp_q.push_back(e); end
      end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endfunction

  task automatic pin(input int idx, input logic [15:0] a, input matrix_id_t id, input logic last);
    if (idx >= exp_q.size()) begin
      chk("model_len", idx, exp_q.size());
    end else begin
      chk("model_addr", exp_q[idx].a, a);
      chk("model_id", exp_q[idx].id, id);
      chk("model_last", exp_q[idx].last, last);
    end
  endtask

  // random ready when rmode is set; otherwise tasks own addr_ready
  initial forever begin
    @(posedge clk); #2;
    if (rmode) addr_ready = ($urandom_range(0, 3) != 0);
  end

  // transfer checker + hold-under-stall checker
  logic        stall_pend = 1'b0;
  logic [15:0] p_addr;
  matrix_id_t  p_id;
  logic        p_last;
  always @(negedge clk) begin
    exp_t e;
    if (stall_pend) begin
      chk("stall_valid", addr_valid, 1'b1);
      chk("stall_addr", addr, p_addr);
      chk("stall_id", addr_id, p_id);
      chk("stall_last", addr_last, p_last);
    end
    if (!addr_valid) begin
      if (addr !== 16'h0 || addr_id !== MAT_INVALID || addr_last !== 1'b0)
        chk("idle_outs", {addr, 6'd0, addr_id, addr_last}, {16'h0, 6'd0, MAT_INVALID, 1'b0});
    end
    if (addr_valid && addr_ready && !abort && !rst) begin
      if (exp_q.size() == 0) chk("extra_xfer", addr, 32'hFFFF_FFFF);
      else begin
        e = exp_q.pop_front();
        chk("xfer_addr", addr, e.a);
        chk("xfer_id", addr_id, e.id);
        chk("xfer_last", addr_last, e.last);
        if (e.last) last_cyc = cyc;
      end
    end
    stall_pend = addr_valid && !addr_ready && !abort && !rst;
    p_addr = addr; p_id = addr_id; p_last = addr_last;
  end

  task automatic start_job(input int m, input int n, input int k, input logic [2:0] en,
                           input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                           input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] sc);
    @(posedge clk); #1;
    cfg_m = 8'(m); cfg_n = 8'(n); cfg_k = 8'(k); phase_en = en;
    base_a = ba; base_b = bb; base_c = bc;
    stride_a = sa; stride_b = sb; stride_c = sc;
    start = 1'b1;
    @(posedge clk); #1;          // start sampled, now INIT
    start = 1'b0;
    @(posedge clk); #1;          // config latched, now GEN (or IDLE if empty)
    // config must be ignored from here on
    cfg_m = 8'($urandom); cfg_n = 8'($urandom); cfg_k = 8'($urandom);
    phase_en = 3'($urandom); base_a = 16'($urandom); base_b = 16'($urandom);
    base_c = 16'($urandom); stride_a = 16'($urandom); stride_b = 16'($urandom);
    stride_c = 16'($urandom);
  endtask

  task automatic finish_job();
    bit got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    chk("done_seen", got, 1'b1);
    chk("queue_drained", exp_q.size(), 0);
    chk("done_timing", cyc, last_cyc + 1);
    chk("busy_after_done", busy, 1'b0);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
  endtask

  task automatic run_job(input int m, input int n, input int k, input logic [2:0] en,
                         input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                         input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] sc);
    int len;
    build(m, n, k, en, ba, bb, bc, sa, sb, sc);
    len = exp_q.size();
    start_job(m, n, k, en, ba, bb, bc, sa, sb, sc);
    @(negedge clk);              // two cycles after start was sampled
    if (len == 0) begin
      chk("empty_done", done, 1'b1);
      chk("empty_busy", busy, 1'b0);
      chk("empty_valid", addr_valid, 1'b0);
      @(negedge clk);
      chk("empty_done_pulse", done, 1'b0);
    end else begin
      chk("first_valid", addr_valid, 1'b1);
      chk("busy_gen", busy, 1'b1);
      if (len >= 8) begin
        // start while busy must be ignored
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      finish_job();
    end
  endtask

  task automatic cut_job(input bit use_rst);
    build(1, 2, 2, 3'b111, 16'h100, 16'h200, 16'h300, 16'h0, 16'h40, 16'h0);
    start_job(1, 2, 2, 3'b111, 16'h100, 16'h200, 16'h300, 16'h0, 16'h40, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else abort = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk(use_rst ? "rst_valid" : "abort_valid", addr_valid, 1'b0);
    chk(use_rst ? "rst_busy" : "abort_busy", busy, 1'b0);
    chk(use_rst ? "rst_done" : "abort_done", done, 1'b0);
    chk(use_rst ? "rst_addr" : "abort_addr", addr, 16'h0);
    chk(use_rst ? "rst_id" : "abort_id", addr_id, MAT_INVALID);
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_cut", {done, busy}, 2'b00);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; addr_ready = 1'b1;
    cfg_m = '0; cfg_n = '0; cfg_k = '0; phase_en = '0;
    base_a = '0; base_b = '0; base_c = '0; stride_a = '0; stride_b = '0; stride_c = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", addr_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_addr", addr, 16'h0);
    chk("reset_id", addr_id, MAT_INVALID);
    chk("reset_last", addr_last, 1'b0);
    // reset beats start
    cfg_m = 1; cfg_n = 1; cfg_k = 1; phase_en = 3'b111; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_over_start", busy, 1'b0);
    // abort in IDLE is inert
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("idle_abort", {busy, done, addr_valid}, 3'b000);

    // 1x1x1, all phases
    build(1, 1, 1, 3'b111, 16'h100, 16'h200, 16'h300, 16'h0, 16'h0, 16'h0);
    pin(0, 16'h100, MAT_A, 1'b0); pin(1, 16'h200, MAT_B, 1'b0); pin(2, 16'h300, MAT_C, 1'b1);
    run_job(1, 1, 1, 3'b111, 16'h100, 16'h200, 16'h300, 16'h0, 16'h0, 16'h0);

    // M=1, N=2, K=2, stride_b=0x40
    build(1, 2, 2, 3'b111, 16'h100, 16'h200, 16'h300, 16'h0, 16'h40, 16'h0);
    pin(0, 16'h100, MAT_A, 0); pin(1, 16'h200, MAT_B, 0); pin(2, 16'h110, MAT_A, 0);
    pin(3, 16'h240, MAT_B, 0); pin(4, 16'h300, MAT_C, 0); pin(5, 16'h100, MAT_A, 0);
    pin(6, 16'h210, MAT_B, 0); pin(7, 16'h110, MAT_A, 0); pin(8, 16'h250, MAT_B, 0);
    pin(9, 16'h310, MAT_C, 1);
    run_job(1, 2, 2, 3'b111, 16'h100, 16'h200, 16'h300, 16'h0, 16'h40, 16'h0);

    // C only
    build(2, 2, 3, 3'b100, 16'h100, 16'h200, 16'h300, 16'h0, 16'h0, 16'h80);
    pin(0, 16'h300, MAT_C, 0); pin(1, 16'h310, MAT_C, 0);
    pin(2, 16'h380, MAT_C, 0); pin(3, 16'h390, MAT_C, 1);
    run_job(2, 2, 3, 3'b100, 16'h100, 16'h200, 16'h300, 16'h0, 16'h0, 16'h80);

    // stall on the second address: B held four cycles
    build(1, 1, 1, 3'b111, 16'h100, 16'h200, 16'h300, 16'h0, 16'h0, 16'h0);
    start_job(1, 1, 1, 3'b111, 16'h100, 16'h200, 16'h300, 16'h0, 16'h0, 16'h0);
    @(posedge clk); #1 addr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_b_addr", addr, 16'h200);
      chk("stall_b_id", addr_id, MAT_B);
      @(posedge clk); #1;
      if (i == 2) addr_ready = 1'b1;
    end
    finish_job();

    // K=0: nothing emitted, immediate done
    run_job(2, 2, 0, 3'b111, 16'h100, 16'h200, 16'h300, 16'h10, 16'h20, 16'h30);
    run_job(2, 2, 2, 3'b000, 16'h100, 16'h200, 16'h300, 16'h10, 16'h20, 16'h30);

    cut_job(1'b0);
    cut_job(1'b1);

    // randomized jobs with random backpressure
    rmode = 1'b1;
    for (int j = 0; j < 40; j++) begin
      run_job($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 3'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom),
              16'($urandom), 16'($urandom), 16'($urandom));
    end
    rmode = 1'b0;
    addr_ready = 1'b1;
    run_job(3, 2, 2, 3'b011, 16'hFFF0, 16'hFF00, 16'h0, 16'h1000, 16'h2000, 16'h0);
    cut_job(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
